// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and sample voting helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (1 start, NUMBER_OF_BITS data LSB-first, 1 stop) with valid/ready byte output.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote at each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 8,
    parameter int BAUD_DIVIDER   = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [NUMBER_OF_BITS-1:0] data_bits,
    output logic                      frame_error,
    output logic                      overrun
);

    localparam int RATE_W = $clog2(BAUD_DIVIDER);
    localparam int BIT_W  = $clog2(NUMBER_OF_BITS + 1);
    localparam logic [RATE_W-1:0] RATE_HALF = RATE_W'(BAUD_DIVIDER / 2 - 1);
    localparam logic [RATE_W-1:0] RATE_FULL = RATE_W'(BAUD_DIVIDER - 1);
    localparam logic [BIT_W-1:0]  BIT_COUNT = BIT_W'(NUMBER_OF_BITS);

    uart_rx_state_t              state_q, state_d;
    logic [RATE_W-1:0]           rate_q, rate_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [NUMBER_OF_BITS-1:0]   shift_q, shift_d;
    logic [NUMBER_OF_BITS-1:0]   bits_q, bits_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        ovr_q, ovr_d;
    logic                        rx_s;
    logic                        sample_bit;
    logic                        sample_tick;
    logic                        deliver;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync_rx (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) hist_q <= 2'b11;
        else          hist_q <= {hist_q[0], rx_s};
    end

    assign sample_bit = majority3(rx_s, hist_q[0], hist_q[1]);
`else
    assign sample_bit = rx_s;
`endif

    assign sample_tick = (rate_q == '0);

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;

        if (state_q == START || state_q == DATA || state_q == STOP) begin
            rate_d = sample_tick ? RATE_FULL : rate_q - RATE_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rx_s == START_BIT) begin
                    state_d = START;
                    rate_d  = RATE_HALF;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (sample_bit == START_BIT) begin
                        state_d = DATA;
                        bit_d   = BIT_COUNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    shift_d = {sample_bit, shift_q[NUMBER_OF_BITS-1:1]};
                    bit_d   = bit_q - BIT_W'(1);
                    if (bit_q == BIT_W'(1)) state_d = STOP;
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (sample_bit == STOP_BIT) begin
                        state_d = IDLE;
                        deliver = 1'b1;
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            BREAK: begin
                // A held-low line must go idle before another start is accepted.
                if (rx_s == STOP_BIT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        bits_d  = bits_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || data_ready) begin
                bits_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rate_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_valid  = valid_q;
    assign data_bits   = bits_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model of delivery/overrun/frame errors plus directed checks.
module tb_uart_rx;

    localparam int NB  = 8;
    localparam int BD  = 4;
    localparam int LAT = 3 + BD / 2 + (NB + 1) * BD;

    logic          clock;
    logic          reset_n;
    logic          rx;
    logic          data_valid;
    logic          data_ready;
    logic [NB-1:0] data_bits;
    logic          frame_error;
    logic          overrun;

    uart_rx #(.NUMBER_OF_BITS(NB), .BAUD_DIVIDER(BD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_bits   (data_bits),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int          cyc;
        logic [7:0]  b;
        logic        good;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        ev;
    logic [7:0] acc_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         vcnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_bits = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    // Frame-level model: each frame produces one event LAT cycles after its start edge.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            m_valid = 1'b0;
            m_bits  = 8'h00;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            ev_q.delete();
        end else begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                ev = ev_q.pop_front();
                if (!ev.good) begin
                    m_ferr = 1'b1;
                    if (m_valid && data_ready) m_valid = 1'b0;
                end else if (!m_valid || data_ready) begin
                    m_bits  = ev.b;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            checks++;
            if ({data_valid, data_bits, frame_error, overrun} !== {m_valid, m_bits, m_ferr, m_ovr}) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d got v=%b d=%h fe=%b ov=%b expected v=%b d=%h fe=%b ov=%b",
                         cyc, data_valid, data_bits, frame_error, overrun, m_valid, m_bits, m_ferr, m_ovr);
            end
            if (data_valid) vcnt++;
            if (frame_error) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (data_valid && data_ready) acc_q.push_back(data_bits);
        end
    end

    task automatic check_i(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_b(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at posedge+1; drives one full frame, one line level per cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
        logic [9:0] fr;
        ev_t        e;
        fr     = {stop, b, 1'b0};
        e.cyc  = cyc + LAT;
        e.b    = b;
        e.good = stop;
        ev_q.push_back(e);
        for (int c = 0; c < 10 * BD; c++) begin
            rx = (c == glitch) ? ~fr[c / BD] : fr[c / BD];
            @(posedge clock);
            #1;
        end
        rx = 1'b1;
    endtask

    function automatic logic [7:0] acc_last();
        if (acc_q.size() == 0) return 8'hxx;
        return acc_q[acc_q.size() - 1];
    endfunction

    initial begin
        int k0;
        int lat;
        int v0;
        int f0;
        int o0;

        reset_n    = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b1;
        #2;
        check_i("reset_valid", int'(data_valid), 0);
        check_b("reset_bits", data_bits, 8'h00);
        check_i("reset_ferr", int'(frame_error), 0);
        check_i("reset_ovr", int'(overrun), 0);
        idle(3);
        reset_n = 1'b1;
        idle(5);

        // Single frame, exact latency from start edge.
        k0 = cyc;
        send_frame(8'hA5, 1'b1, -1);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (data_valid) begin
                lat = cyc - k0;
                break;
            end
        end
        check_i("latency_a5", lat, 41);
        check_b("data_a5", data_bits, 8'hA5);
        @(negedge clock);
        check_i("valid_drop_a5", int'(data_valid), 0);
        @(posedge clock);
        #1;
        idle(4);

        // One-cycle low glitch is a false start.
        v0 = vcnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(20);
        check_i("glitch_no_valid", vcnt, v0);
        check_i("glitch_no_ferr", ferr_cnt, f0);
        send_frame(8'h3C, 1'b1, -1);
        idle(6);
        check_b("after_glitch_3c", acc_last(), 8'h3C);

        // Stop bit low.
        v0 = vcnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        idle(10);
        check_i("framing_pulse", ferr_cnt - f0, 1);
        check_i("framing_no_valid", vcnt, v0);

        // Overrun with a stalled consumer.
        data_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(5);
        check_b("overrun_hold_11", data_bits, 8'h11);
        check_i("overrun_valid", int'(data_valid), 1);
        check_i("overrun_pulse", ovr_cnt - o0, 1);
        data_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_i("overrun_valid_drop", int'(data_valid), 0);
        check_b("overrun_accept_11", acc_last(), 8'h11);
        @(posedge clock);
        #1;
        idle(4);

        // Back-to-back frames.
        acc_q.delete();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        idle(10);
        check_i("b2b_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check_b("b2b_0", acc_q[0], 8'h00);
            check_b("b2b_1", acc_q[1], 8'hFF);
            check_b("b2b_2", acc_q[2], 8'h55);
        end

        // Reset during data bit 3 of a frame.
        rx = 1'b0;
        idle(BD);
        for (int b = 0; b < 3; b++) begin
            rx = (b == 1);
            idle(BD);
        end
        rx = 1'b1;
        idle(2);
        reset_n = 1'b0;
        #1;
        check_i("midreset_valid", int'(data_valid), 0);
        check_b("midreset_bits", data_bits, 8'h00);
        rx = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b1, -1);
        idle(6);
        check_b("after_reset_5a", acc_last(), 8'h5A);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // Inverted glitch on the bit-2 sample cycle is outvoted.
        send_frame(8'hF0, 1'b1, 2 * BD + 2 + BD / 2);
        idle(6);
        check_b("majority_f0", acc_last(), 8'hF0);
`endif

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
